// File: rtl/spi_pkg.sv
// spi_pkg: frame constants and controller states shared by the SPI register writer and its peripheral
package spi_pkg;
    localparam int FRAME_W   = 16;
    localparam int ADDR_W    = 7;
    localparam int DATA_W    = 8;
    localparam int WRITE_BIT = 15;
    localparam int NUM_REGS  = 5;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP, REJECT} state_t;
endpackage

// File: rtl/spi_reg_writer_if.sv
// spi_reg_writer_if: request handshake plus SPI pins of the register writer
interface spi_reg_writer_if;
    import spi_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              busy;
    logic              done;
    logic              err;

    modport master (output req_valid, req_addr, req_data,
                    input  req_ready, sclk, cs_n, mosi, busy, done, err);
    modport slave  (input  req_valid, req_addr, req_data,
                    output req_ready, sclk, cs_n, mosi, busy, done, err);
endinterface

// File: rtl/spi_sclk_gen.sv
// spi_sclk_gen: divides clk into sclk half-periods of CLK_DIV cycles while enabled
module spi_sclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sclk,
    output logic rise,
    output logic fall
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;
    logic          run;

    // The divider parks at LAST with sclk low, so the first enabled edge raises sclk.
    // rise marks the end of a low phase while running, fall the end of a high phase.
    assign rise = run && !sclk && cnt == LAST;
    assign fall = sclk && cnt == LAST;

    // Half-period counter toggling sclk each time it wraps
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk <= 1'b0;
            cnt  <= LAST;
            run  <= 1'b0;
        end else begin
            run <= en;
            if (!en) begin
                sclk <= 1'b0;
                cnt  <= LAST;
            end else if (cnt == LAST) begin
                sclk <= !sclk;
                cnt  <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/spi_reg_writer.sv
// spi_reg_writer: serialises (addr, data) write requests as 16-bit mode-0 SPI frames
module spi_reg_writer
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int IDLE_GAP = 8
) (
    input logic              clk,
    input logic              rst_n,
    spi_reg_writer_if.slave  bus
);
    localparam int TW = 16;

    state_t             state, state_n;
    logic [FRAME_W-1:0] sh, sh_n;
    logic [4:0]         bit_cnt, bit_n;
    logic [TW-1:0]      tcnt, tcnt_n;
    logic               rise, fall, on_bus;

    spi_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (state_n == SHIFT),
        .sclk (bus.sclk),
        .rise (rise),
        .fall (fall)
    );

    assign on_bus = state_n inside {SETUP, SHIFT, HOLD};

    // Next state, frame shifting and phase counting; outputs are registered from these
    always_comb begin
        state_n = state;
        sh_n    = sh;
        bit_n   = bit_cnt;
        tcnt_n  = tcnt + 1'b1;
        case (state)
            IDLE: begin
                tcnt_n = '0;
                if (bus.req_valid) begin
                    sh_n            = {1'b0, bus.req_addr, bus.req_data};
                    sh_n[WRITE_BIT] = 1'b1;
                    bit_n           = '0;
                    state_n         = (bus.req_addr >= ADDR_W'(NUM_REGS)) ? REJECT : SETUP;
                end
            end
            SETUP: if (tcnt == TW'(CS_SETUP - 1)) begin
                state_n = SHIFT;
                tcnt_n  = '0;
            end
            SHIFT: begin
                if (fall) begin
                    bit_n = (bit_cnt == 5'(FRAME_W)) ? bit_cnt : bit_cnt + 5'd1;
                    if (bit_cnt < 5'(FRAME_W - 1)) sh_n = sh << 1;
                end
                if (rise && bit_cnt == 5'(FRAME_W)) begin
                    state_n = HOLD;
                    tcnt_n  = '0;
                end
            end
            HOLD: if (tcnt == TW'(CS_HOLD - 1)) begin
                state_n = GAP;
                tcnt_n  = '0;
            end
            GAP: if (tcnt == TW'(IDLE_GAP - 1)) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, frame and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            sh            <= '0;
            bit_cnt       <= '0;
            tcnt          <= '0;
            bus.cs_n      <= 1'b1;
            bus.mosi      <= 1'b0;
            bus.req_ready <= 1'b1;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
        end else begin
            state         <= state_n;
            sh            <= sh_n;
            bit_cnt       <= bit_n;
            tcnt          <= tcnt_n;
            bus.cs_n      <= !on_bus;
            bus.mosi      <= on_bus && sh_n[FRAME_W-1];
            bus.req_ready <= state_n == IDLE;
            bus.busy      <= state_n != IDLE;
            bus.done      <= state_n == REJECT || (state_n == GAP && tcnt_n == TW'(IDLE_GAP - 1));
            bus.err       <= state_n == REJECT;
        end
    end
endmodule

// File: tb/tb_spi_reg_writer.sv
// tb_spi_reg_writer: directed stimulus checked against a cycle-offset model of the SPI frame
module tb_spi_reg_writer;
    import spi_pkg::*;
    localparam int D   = 4;
    localparam int S   = 2;
    localparam int H   = 2;
    localparam int G   = 8;
    localparam int CSL = S + 32 * D + H;
    localparam int TOT = CSL + G;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    spi_reg_writer_if bus();

    spi_reg_writer #(.CLK_DIV(D), .CS_SETUP(S), .CS_HOLD(H), .IDLE_GAP(G)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: k counts cycles since the accepting edge; outputs follow from k alone
    bit          act = 1'b0;
    bit          rej = 1'b0;
    int          k = 0;
    int          hs_cnt = 0;
    logic [15:0] mframe = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) act <= 1'b0;
        else if (!act) begin
            if (bus.req_valid) begin
                act    <= 1'b1;
                k      <= 1;
                rej    <= bus.req_addr >= 7'(NUM_REGS);
                mframe <= {1'b1, bus.req_addr, bus.req_data};
                hs_cnt <= hs_cnt + 1;
            end
        end else if (k == (rej ? 1 : TOT)) act <= 1'b0;
        else k <= k + 1;
    end

    function automatic logic [6:0] model_out();
        int f;
        logic sc, csn, mo;
        if (!act) return 7'b0101000;
        if (rej) return 7'b0100111;
        csn = !(k <= CSL);
        sc  = k > S && k <= S + 32 * D && ((k - S - 1) / D) % 2 == 0;
        f   = (k > S) ? (k - S - 1 + D) / (2 * D) : 0;
        if (f > 15) f = 15;
        mo  = !csn && mframe[15 - f];
        return {sc, csn, mo, 1'b0, 1'b1, k == TOT, 1'b0};
    endfunction

    always @(negedge clk) begin
        logic [6:0] got, want;
        got  = {bus.sclk, bus.cs_n, bus.mosi, bus.req_ready, bus.busy, bus.done, bus.err};
        want = model_out();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cycle %0d outputs {sclk,cs_n,mosi,ready,busy,done,err} got %b want %b", cyc, got, want);
        end
    end

    // Peripheral stand-in: commits complete write frames when cs_n rises
    logic [7:0]  periph [NUM_REGS] = '{default: '0};
    logic [15:0] cap = '0;
    logic [15:0] last_frame = '0;
    int rises = 0, last_rises = 0, sclk_edges = 0, cs_falls = 0, busy_rises = 0;
    int low_run = 0, high_run = 0, last_low = 0, last_high = 0;

    always @(negedge bus.cs_n) begin rises = 0; cs_falls++; end
    always @(posedge bus.busy) busy_rises++;
    always @(bus.sclk) sclk_edges++;
    always @(posedge bus.sclk) if (bus.cs_n === 1'b0) begin cap = {cap[14:0], bus.mosi}; rises++; end
    always @(posedge bus.cs_n) begin
        last_frame = cap;
        last_rises = rises;
        if (rises == 16 && cap[15] && cap[14:8] < 7'(NUM_REGS)) periph[cap[14:8]] = cap[7:0];
    end
    always @(negedge clk) begin
        if (bus.cs_n === 1'b0) begin
            low_run++;
            if (high_run != 0) last_high = high_run;
            high_run = 0;
        end else begin
            high_run++;
            if (low_run != 0) last_low = low_run;
            low_run = 0;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h", name, got, want);
        end
    endtask

    task automatic send(input int a, input int d, output int t);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'(a);
        bus.req_data  = 8'(d);
        t = cyc;
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (act && n < 400) begin @(negedge clk); n++; end
        if (act) check("idle_timeout", 0, 1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t, t1, n, e0, c0, b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {bus.sclk, bus.cs_n, bus.mosi, bus.req_ready, bus.busy, bus.done, bus.err}, 7'b0101000);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        send(2, 'hA5, t);
        n = 0;
        while (bus.done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("done_latency", cyc - t, 140);
        @(negedge clk);
        check("ready_after_done", bus.req_ready, 1);
        check("frame_a5", last_frame, 'h82A5);
        check("rises_a5", last_rises, 16);
        check("cs_low_a5", last_low, 132);
        check("reg3_a5", periph[2], 'hA5);
        check("reg1_unchanged", periph[0], 0);

        e0 = sclk_edges;
        c0 = cs_falls;
        send(5, 'hFF, t);
        check("reject_done_err", {bus.done, bus.err, bus.cs_n}, 3'b111);
        @(negedge clk);
        check("reject_ready", bus.req_ready, 1);
        repeat (4) @(negedge clk);
        check("reject_no_sclk", sclk_edges - e0, 0);
        check("reject_no_cs", cs_falls - c0, 0);

        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'd0;
        bus.req_data  = 8'h11;
        t1 = cyc;
        @(negedge clk);
        bus.req_addr = 7'd4;
        bus.req_data = 8'h44;
        n = 0;
        while (bus.req_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
        check("b2b_ready_offset", cyc - t1, 141);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("b2b_second_accept", {bus.busy, bus.cs_n}, 2'b10);
        wait_idle();
        check("b2b_gap_ge8", last_high >= G, 1);
        check("reg1_11", periph[0], 'h11);
        check("reg5_44", periph[4], 'h44);

        send(0, 'h77, t);
        n = 0;
        while (rises < 7 && n < 200) begin @(negedge clk); n++; end
        check("rst_seen_7_rises", rises, 7);
        #2 rst_n = 1'b0;
        #1 check("async_cs_n_sclk", {bus.cs_n, bus.sclk, bus.busy}, 3'b100);
        @(negedge clk);
        #2 rst_n = 1'b1;
        send(1, 'h33, t);
        wait_idle();
        check("reg2_33", periph[1], 'h33);
        check("reg1_after_abort", periph[0], 'h11);

        b0 = busy_rises;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 7'd3;
        bus.req_data  = 8'h5C;
        for (int i = 0; i < 130; i++) begin
            @(negedge clk);
            bus.req_valid = 1'($urandom);
            bus.req_addr  = 7'($urandom);
            bus.req_data  = 8'($urandom);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        wait_idle();
        check("rand_frame", last_frame, 'h835C);
        check("rand_single_accept", busy_rises - b0, 1);
        check("reg4_5c", periph[3], 'h5C);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
